usr_sw_led_ctrl: RTL and testbench
==================================

// Module: usr_sw_led_ctrl
// PURPOSE
//  Front-panel I/O stage between the board pins and the FTop core.
//  - Upstream side: synchronises and debounces the 8 raw usr_sw dip-switches.
//  - Downstream side: drives the 8 board leds from one of four selectable
//    sources, with an optional PWM dimmer.
//  Sits at the top level; sw_db/sw_chg feed the core, core status feeds status_in.
// PARAMETERS
//  TICK_DIV    100000  sample-tick period in sys0_clk cycles (1 ms at 100 MHz); >=2
//  DB_SAMPLES  8       consecutive equal samples required to accept a switch level; 2..16
//  HB_W        27      heartbeat counter width (msb toggles about every 0.67 s at 100 MHz); >=9
// PORTS
//  sys0_clk   in   1  100MHz free-running clock; sole clock domain
//  sys0_rst   in   1  synchronous, active-high reset
//  usr_sw     in   8  raw dip-switch pins, asynchronous, may bounce
//  status_in  in   8  core status bits to display
//  sw_db      out  8  debounced switch levels
//  sw_chg     out  8  one-cycle pulse per bit when sw_db[i] changes
//  led        out  8  registered led drive, active-high
// BEHAVIOUR
//  Reset (sys0_rst=1 at a clock edge): clears sync flops, tick counter,
//  history regs, hb_cnt and pwm_cnt; drives sw_db=0, sw_chg=0, led=0.
//  Reset asserted mid-debounce discards all partial history.
//  Synchroniser: 2-flop chain per bit -> usr_sw_s.
//  Tick: tick_cnt counts 0..TICK_DIV-1 and wraps; tick=1 for the single cycle
//    where tick_cnt==TICK_DIV-1.
//  Debounce, per bit i, on tick only:
//    hist_i <= {hist_i[DB_SAMPLES-2:0], usr_sw_s[i]}.
//    If the new hist_i is all-1 and sw_db[i]=0: sw_db[i]<=1 and sw_chg[i]<=1.
//    If the new hist_i is all-0 and sw_db[i]=1: sw_db[i]<=0 and sw_chg[i]<=1.
//    Any mixed history: sw_db[i] holds; a bounce restarts qualification.
//  sw_chg is 0 on every other cycle, so it is high exactly one cycle,
//    coincident with the sw_db edge.
//  Latency: a clean step on usr_sw reaches sw_db within
//    2 + DB_SAMPLES*TICK_DIV cycles; the minimum is 2 + (DB_SAMPLES-1)*TICK_DIV + 1.
//  Heartbeat: hb_cnt is a HB_W-bit free-running up-counter; it wraps to 0 silently.
//  LED source select uses mode = sw_db[7:6]; led is registered, 1 cycle after
//    the source changes:
//    00: led <= status_in
//    01: led <= sw_db
//    10: led <= {hb_cnt[HB_W-1], hb_cnt[HB_W-2 -: 7]}
//    11: led <= 8'hFF (lamp test)
//  A mode change takes effect on the cycle after the sw_db update.
//  Simultaneous events: all 8 bits debounce independently in the same tick;
//    several sw_chg bits may pulse together.
// CONFIGURATION
//  LED_PWM_EN defined:
//    - 4-bit free-running pwm_cnt.
//    - duty = {sw_db[5:4], 2'b11}.
//    - led <= src & {8{pwm_cnt <= duty}}, giving on-fractions 4/16, 8/16,
//      12/16 and 16/16.
//    - Reset clears pwm_cnt.
//  LED_PWM_EN undefined:
//    - No pwm_cnt.
//    - led <= src, always at full brightness.
//    - sw_db[5:4] has no led effect.
// TESTING (sim params TICK_DIV=4, DB_SAMPLES=3, HB_W=12)
//  1 Reset: hold sys0_rst 3 cycles with usr_sw=8'hFF -> led=0, sw_db=0,
//    sw_chg=0 during reset and the first cycle after.
//  2 Clean step: usr_sw 00->01 -> sw_db=8'h01 within 2+3*4=14 cycles;
//    sw_chg=8'h01 for exactly 1 cycle; no other bits move.
//  3 Bounce: usr_sw[2] toggles every 3 cycles for 40 cycles, then holds 1
//    -> sw_db[2] stays 0 during the bounce, rises <=14 cycles after it stops.
//  4 Modes: status_in=8'hA5, sw 8'h00 -> led=A5; sw 8'h40 -> led=40;
//    sw 8'hC0 -> led=FF; sw 8'h80 -> led tracks hb_cnt[11:4], msb period 4096.
//  5 Reset mid-debounce: assert sys0_rst when hist holds 2 of 3 ones -> after
//    release, 3 further ticks are required before sw_db updates.
//  6 LED_PWM_EN: mode 11, sw[5:4]=01 -> led=FF for 8 of every 16 cycles,
//    otherwise 00; run the same test undefined -> led constantly FF.

Source files
------------

// File: rtl/usr_sw_led_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : usr_sw_led_ctrl_if
// Description : Front-panel pin/core bundle for usr_sw_led_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface usr_sw_led_ctrl_if;
  logic [7:0] usr_sw;
  logic [7:0] status_in;
  logic [7:0] sw_db;
  logic [7:0] sw_chg;
  logic [7:0] led;

  modport master (
    output usr_sw,
    output status_in,
    input  sw_db,
    input  sw_chg,
    input  led
  );

  modport slave (
    input  usr_sw,
    input  status_in,
    output sw_db,
    output sw_chg,
    output led
  );
endinterface
`default_nettype wire

// File: rtl/usr_sw_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usr_sw_led_ctrl
// Description : Synchronises/debounces 8 dip-switches and drives 8 leds from a
//               switch-selected source. Optional PWM dimmer: LED_PWM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_sw_led_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int DB_SAMPLES = 8,
  parameter int HB_W       = 27
) (
  input wire               sys0_clk,
  input wire               sys0_rst,
  usr_sw_led_ctrl_if.slave io
);

  localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

  logic [7:0]            sync1_q, sync1_d;
  logic [7:0]            sync2_q, sync2_d;
  logic [c_tick_w-1:0]   tick_cnt_q, tick_cnt_d;
  logic                  tick;
  logic [DB_SAMPLES-1:0] hist_q [8];
  logic [DB_SAMPLES-1:0] hist_d [8];
  logic [DB_SAMPLES-1:0] hist_shift [8];
  logic [7:0]            qual_hi;
  logic [7:0]            qual_lo;
  logic [7:0]            sw_db_q, sw_db_d;
  logic [7:0]            sw_chg_q, sw_chg_d;
  logic [7:0]            led_q, led_d;
  logic [7:0]            led_src;
  logic [HB_W-1:0]       hb_cnt_q, hb_cnt_d;
`ifdef LED_PWM_EN
  logic [3:0]            pwm_cnt_q, pwm_cnt_d;
  logic [3:0]            duty;
`endif

  // History as it will look after this tick's sample is shifted in.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign hist_shift[gi] = {hist_q[gi][DB_SAMPLES-2:0], sync2_q[gi]};
    assign qual_hi[gi]    = &hist_shift[gi];
    assign qual_lo[gi]    = ~|hist_shift[gi];
  end

  assign tick = (tick_cnt_q == c_tick_last);

  always_comb begin
    sync1_d    = io.usr_sw;
    sync2_d    = sync1_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + c_tick_w'(1);
    hist_d     = hist_q;
    sw_db_d    = sw_db_q;
    sw_chg_d   = '0;
    hb_cnt_d   = hb_cnt_q + HB_W'(1);
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        hist_d[i] = hist_shift[i];
        if (qual_hi[i] && !sw_db_q[i]) begin
          sw_db_d[i]  = 1'b1;
          sw_chg_d[i] = 1'b1;
        end else if (qual_lo[i] && sw_db_q[i]) begin
          sw_db_d[i]  = 1'b0;
          sw_chg_d[i] = 1'b1;
        end
      end
    end
  end

  // Mode comes from the registered sw_db, so a mode change lands one cycle later.
  always_comb begin
    led_src = io.status_in;
    case (sw_db_q[7:6])
      2'b00:   led_src = io.status_in;
      2'b01:   led_src = sw_db_q;
      2'b10:   led_src = {hb_cnt_q[HB_W-1], hb_cnt_q[HB_W-2 -: 7]};
      default: led_src = 8'hFF;
    endcase
`ifdef LED_PWM_EN
    duty      = {sw_db_q[5:4], 2'b11};
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    led_d     = led_src & {8{pwm_cnt_q <= duty}};
`else
    led_d     = led_src;
`endif
  end

  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      for (int i = 0; i < 8; i++) begin
        hist_q[i] <= '0;
      end
      sw_db_q    <= '0;
      sw_chg_q   <= '0;
      led_q      <= '0;
      hb_cnt_q   <= '0;
`ifdef LED_PWM_EN
      pwm_cnt_q  <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      hist_q     <= hist_d;
      sw_db_q    <= sw_db_d;
      sw_chg_q   <= sw_chg_d;
      led_q      <= led_d;
      hb_cnt_q   <= hb_cnt_d;
`ifdef LED_PWM_EN
      pwm_cnt_q  <= pwm_cnt_d;
`endif
    end
  end

  assign io.sw_db  = sw_db_q;
  assign io.sw_chg = sw_chg_q;
  assign io.led    = led_q;

endmodule
`default_nettype wire

// File: tb/tb_usr_sw_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usr_sw_led_ctrl
// Description : Scoreboard bench for usr_sw_led_ctrl (honours LED_PWM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usr_sw_led_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int DB_SAMPLES = 3;
  localparam int HB_W       = 12;

  logic sys0_clk = 1'b0;
  logic sys0_rst = 1'b1;

  usr_sw_led_ctrl_if bus ();

  usr_sw_led_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DB_SAMPLES (DB_SAMPLES),
    .HB_W       (HB_W)
  ) dut (
    .sys0_clk (sys0_clk),
    .sys0_rst (sys0_rst),
    .io       (bus)
  );

  always #5 sys0_clk = ~sys0_clk;

  int          checks  = 0;
  int          errors  = 0;
  int          n_edges = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  logic [7:0]  model_db = 8'h00;
  logic [7:0]  prev_db  = 8'h00;
  bit          mon_en   = 1'b0;

  // Clock edges since the last edge that saw reset.
  always @(posedge sys0_clk) begin
    if (sys0_rst) n_edges = 0;
    else          n_edges = n_edges + 1;
  end

  // Every sw_db move or sw_chg pulse must match the next queued expectation.
  always @(posedge sys0_clk) begin
    #1;
    if (mon_en && (bus.sw_chg !== 8'h00 || bus.sw_db !== prev_db)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sw_event_unexpected: sw_db=%h sw_chg=%h, required sw_db=%h sw_chg=00",
                 bus.sw_db, bus.sw_chg, prev_db);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.sw_db, bus.sw_chg} !== mon_e) begin
          errors++;
          $display("FAIL sw_event: sw_db=%h sw_chg=%h, required sw_db=%h sw_chg=%h",
                   bus.sw_db, bus.sw_chg, mon_e[15:8], mon_e[7:0]);
        end
      end
    end
    prev_db = bus.sw_db;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] led_exp(input logic [7:0] src);
`ifdef LED_PWM_EN
    logic [3:0] duty;
    int         ph;
    duty = {model_db[5:4], 2'b11};
    ph   = (n_edges - 1) % 16;
    return (ph > int'(duty)) ? 8'h00 : src;
`else
    return src;
`endif
  endfunction

  function automatic logic [7:0] hb_exp();
    int h;
    h = (n_edges - 1) % 4096;
    return h[11:4];
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys0_clk);
      #1;
    end
  endtask

  task automatic drive_sw(input logic [7:0] v);
    if (v !== model_db) exp_q.push_back({v, v ^ model_db});
    model_db   = v;
    bus.usr_sw = v;
  endtask

  task automatic wait_chg(input int bound, output int cyc);
    int i;
    cyc = -1;
    i   = 0;
    while (cyc < 0 && i < bound) begin
      i++;
      step(1);
      if (bus.sw_chg !== 8'h00) cyc = i;
    end
  endtask

  task automatic test_reset;
    bus.usr_sw    = 8'hFF;
    bus.status_in = 8'h00;
    sys0_rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (bus.led !== 8'h00 || bus.sw_db !== 8'h00 || bus.sw_chg !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: led=%h sw_db=%h sw_chg=%h, required 00 00 00",
                 i, bus.led, bus.sw_db, bus.sw_chg);
      end
    end
    sys0_rst = 1'b0;
    step(1);
    checks++;
    if (bus.led !== 8'h00 || bus.sw_db !== 8'h00 || bus.sw_chg !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: led=%h sw_db=%h sw_chg=%h, required 00 00 00",
               bus.led, bus.sw_db, bus.sw_chg);
    end
    bus.usr_sw = 8'h00;
    model_db   = 8'h00;
    step(20);
    checks++;
    if (bus.sw_db !== 8'h00) begin
      errors++;
      $display("FAIL reset_settle: sw_db=%h, required 00", bus.sw_db);
    end
    prev_db = bus.sw_db;
    mon_en  = 1'b1;
  endtask

  task automatic test_clean_step;
    int n0, k, exp_cyc, cyc;
    n0 = n_edges;
    drive_sw(8'h01);
    // First tick able to see the synchronised level, then two more ticks.
    k = n0 + 3;
    while (k % TICK_DIV != 0) k++;
    k       = k + (DB_SAMPLES - 1) * TICK_DIV;
    exp_cyc = k - n0;
    wait_chg(16, cyc);
    checks++;
    if (cyc != exp_cyc || cyc > 14 || cyc < 11) begin
      errors++;
      $display("FAIL clean_step_latency: cycles=%0d, required %0d (within 11..14)", cyc, exp_cyc);
    end
    step(1);
    checks++;
    if (bus.sw_chg !== 8'h00 || bus.sw_db !== 8'h01) begin
      errors++;
      $display("FAIL clean_step_pulse_width: sw_chg=%h sw_db=%h, required 00 01",
               bus.sw_chg, bus.sw_db);
    end
  endtask

  task automatic test_bounce;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      bus.usr_sw = (((i / 3) % 2) == 0) ? 8'h05 : 8'h01;
      step(1);
      checks++;
      if (bus.sw_db !== 8'h01) begin
        errors++;
        $display("FAIL bounce_hold[%0d]: sw_db=%h, required 01", i, bus.sw_db);
      end
    end
    drive_sw(8'h05);
    wait_chg(14, cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL bounce_settle: sw_chg never pulsed within 14 cycles, required a pulse");
    end
  endtask

  task automatic test_modes;
    int         cyc, last_rise, periods;
    logic [7:0] e;
    logic       prev_msb;
    bus.status_in = 8'hA5;
    drive_sw(8'h00);
    wait_chg(16, cyc);
    step(1);
    for (int i = 0; i < 16; i++) begin
      e = led_exp(8'hA5);
      checks++;
      if (bus.led !== e) begin
        errors++;
        $display("FAIL mode00_led: led=%h, required %h", bus.led, e);
      end
      step(1);
    end
    bus.status_in = 8'h3C;
    step(1);
    e = led_exp(8'h3C);
    checks++;
    if (bus.led !== e) begin
      errors++;
      $display("FAIL mode00_status_follow: led=%h, required %h", bus.led, e);
    end

    drive_sw(8'h40);
    wait_chg(16, cyc);
    step(1);
    for (int i = 0; i < 16; i++) begin
      e = led_exp(8'h40);
      checks++;
      if (bus.led !== e) begin
        errors++;
        $display("FAIL mode01_led: led=%h, required %h", bus.led, e);
      end
      step(1);
    end

    drive_sw(8'hC0);
    wait_chg(16, cyc);
    step(1);
    for (int i = 0; i < 16; i++) begin
      e = led_exp(8'hFF);
      checks++;
      if (bus.led !== e) begin
        errors++;
        $display("FAIL mode11_led: led=%h, required %h", bus.led, e);
      end
      step(1);
    end

    drive_sw(8'h80);
    wait_chg(16, cyc);
    step(1);
    last_rise = -1;
    periods   = 0;
    prev_msb  = bus.led[7];
    for (int i = 0; i < 8400; i++) begin
      e = led_exp(hb_exp());
      checks++;
      if (bus.led !== e) begin
        errors++;
        $display("FAIL mode10_led: led=%h, required %h", bus.led, e);
      end
`ifndef LED_PWM_EN
      if (!prev_msb && bus.led[7]) begin
        if (last_rise >= 0) begin
          periods++;
          checks++;
          if (n_edges - last_rise != 4096) begin
            errors++;
            $display("FAIL mode10_msb_period: period=%0d, required 4096", n_edges - last_rise);
          end
        end
        last_rise = n_edges;
      end
      prev_msb = bus.led[7];
`endif
      step(1);
    end
`ifndef LED_PWM_EN
    checks++;
    if (periods == 0) begin
      errors++;
      $display("FAIL mode10_msb_seen: periods=%0d, required at least 1", periods);
    end
`endif
  endtask

  task automatic test_pwm;
    int         cyc, on_cnt, exp_on;
    logic [7:0] e;
    drive_sw(8'hD0);
    wait_chg(16, cyc);
    step(1);
    on_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      e = led_exp(8'hFF);
      checks++;
      if (bus.led !== e) begin
        errors++;
        $display("FAIL pwm_led: led=%h, required %h", bus.led, e);
      end
      if (bus.led === 8'hFF) on_cnt++;
      step(1);
    end
`ifdef LED_PWM_EN
    exp_on = 16;
`else
    exp_on = 32;
`endif
    checks++;
    if (on_cnt != exp_on) begin
      errors++;
      $display("FAIL pwm_on_count: on=%0d of 32, required %0d", on_cnt, exp_on);
    end
  endtask

  task automatic test_reset_mid_debounce;
    int cyc;
    drive_sw(8'h00);
    wait_chg(16, cyc);
    while (n_edges % TICK_DIV != 0) step(1);
    // Two ticks see the new level, leaving hist[1] = 3'b011 when reset hits.
    bus.usr_sw = 8'h02;
    step(8);
    checks++;
    if (bus.sw_db !== 8'h00) begin
      errors++;
      $display("FAIL mid_pre_reset: sw_db=%h, required 00", bus.sw_db);
    end
    sys0_rst = 1'b1;
    step(2);
    checks++;
    if (bus.sw_db !== 8'h00 || bus.sw_chg !== 8'h00 || bus.led !== 8'h00) begin
      errors++;
      $display("FAIL mid_in_reset: sw_db=%h sw_chg=%h led=%h, required 00 00 00",
               bus.sw_db, bus.sw_chg, bus.led);
    end
    sys0_rst = 1'b0;
    exp_q.push_back({8'h02, 8'h02});
    model_db = 8'h02;
    wait_chg(20, cyc);
    checks++;
    if (cyc != 3 * TICK_DIV) begin
      errors++;
      $display("FAIL mid_requalify: cycles=%0d, required %0d", cyc, 3 * TICK_DIV);
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_modes();
    test_pwm();
    test_reset_mid_debounce();
    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
